// File: rtl/multdiv_divider_pkg.sv
// Shared definitions for the multdiv divider: state encoding, default width,
// fixed latency and the two operand patterns that trigger the overflow case.
package multdiv_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Start edge to result edge: WIDTH iteration edges plus one fix-up edge.
    localparam int LATENCY = DEFAULT_WIDTH + 1;

    localparam logic [DEFAULT_WIDTH-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [DEFAULT_WIDTH-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/multdiv_divider_div_nr_step.sv
// One combinational non-restoring division step. The partial remainder is
// shifted left with the next dividend bit, then the divisor magnitude is
// subtracted (remainder >= 0) or added (remainder < 0) through a
// generate/propagate carry-lookahead adder whose carry-in selects subtraction.
module multdiv_divider_div_nr_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH:0]   rem,
    input  logic        [WIDTH-1:0] div_mag,
    input  logic                    div_bit,
    output logic signed [WIDTH:0]   rem_next,
    output logic                    q_bit
);

    logic             sub;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   op_b;
    logic [WIDTH:0]   gen;
    logic [WIDTH:0]   prop;
    logic [WIDTH:0]   carry;

    assign sub     = ~rem[WIDTH];
    assign shifted = {rem[WIDTH-1:0], div_bit};
    // Subtraction is A + ~B + 1; the +1 enters as carry-in.
    assign op_b    = sub ? ~{1'b0, div_mag} : {1'b0, div_mag};
    assign gen     = shifted & op_b;
    assign prop    = shifted ^ op_b;

    // Carry chain from generate/propagate terms, carry-in = subtract select.
    always_comb begin
        // NOTE: every bit gets a default before the loop so no latch is inferred.
        carry    = '0;
        carry[0] = sub;
        for (int i = 0; i < WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign rem_next = prop ^ carry;
    assign q_bit    = ~rem_next[WIDTH];

endmodule

// File: rtl/multdiv_divider.sv
// Multi-cycle signed divider: magnitudes are divided one quotient bit per
// cycle with non-restoring steps, then the sign is applied and the exception
// cases are substituted on a final fix-up edge. Latency is fixed at WIDTH+1.
module multdiv_divider
    import multdiv_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    div_state_e             state;
    div_state_e             state_nxt;
    logic [CNT_W-1:0]       count;
    logic signed [WIDTH:0]  rem_q;
    logic signed [WIDTH:0]  rem_nxt;
    logic [WIDTH-1:0]       dvd_q;
    logic [WIDTH-1:0]       dsr_q;
    logic [WIDTH-1:0]       quot_q;
    logic                   neg_q;
    logic                   zero_q;
    logic                   ovf_q;
    logic                   q_bit;
    logic                   last_step;
    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;

    // INT_MIN negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
    assign a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign last_step = (state == RUN) && (count == CNT_W'(WIDTH - 1));

    multdiv_divider_div_nr_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .div_mag  (dsr_q),
        .div_bit  (dvd_q[WIDTH-1]),
        .rem_next (rem_nxt),
        .q_bit    (q_bit)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next state: a start pulse wins from any state, including FIX.
    always_comb begin
        state_nxt = state;
        if (ctrl_DIV) begin
            state_nxt = RUN;
        end else begin
            unique case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     state_nxt = last_step ? FIX : RUN;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: an operation is in flight in RUN and FIX.
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: operand capture, iteration, and registered result fix-up.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count          <= '0;
            rem_q          <= '0;
            dvd_q          <= '0;
            dsr_q          <= '0;
            quot_q         <= '0;
            neg_q          <= 1'b0;
            zero_q         <= 1'b0;
            ovf_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= (state == FIX);

            // Finishing operation is reported even if a new one starts now.
            if (state == FIX) begin
                if (zero_q) begin
                    data_result <= '0;
                end else if (ovf_q) begin
                    data_result <= INT_MIN;
                end else begin
                    data_result <= neg_q ? -quot_q : quot_q;
                end
                data_exception <= zero_q | ovf_q;
            end

            if (ctrl_DIV) begin
                dvd_q  <= a_mag;
                dsr_q  <= b_mag;
                neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                zero_q <= (data_operandB == '0);
                ovf_q  <= (data_operandA == INT_MIN) && (data_operandB == NEG_ONE);
                rem_q  <= '0;
                quot_q <= '0;
                count  <= '0;
            end else if (state == RUN) begin
                rem_q  <= rem_nxt;
                dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                quot_q <= {quot_q[WIDTH-2:0], q_bit};
                count  <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multdiv_divider.sv
// Self-checking bench for multdiv_divider: directed sign/exception cases,
// randomized operands against an arithmetic reference, restart, start on the
// fix-up edge, and asynchronous reset mid-operation.
module tb_multdiv_divider;
    import multdiv_divider_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clock = 1'b0;
    logic         reset;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    multdiv_divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: signed division truncating toward zero, with the two
    // exception cases substituted.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic e);
        longint sa;
        longint sb;
        longint t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            q = '0;
            e = 1'b1;
        end else if (a == INT_MIN && b == NEG_ONE) begin
            q = INT_MIN;
            e = 1'b1;
        end else begin
            t = sa / sb;
            q = t[W-1:0];
            e = 1'b0;
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the start edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_DIV      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Observe n edges; k counts edges since the call (bounded wait).
    task automatic watch(input int n, output int pulses, output int last_edge,
                         output logic [W-1:0] res, output logic exc, output int busy_cnt);
        pulses    = 0;
        last_edge = -1;
        res       = '0;
        exc       = 1'b0;
        busy_cnt  = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                pulses++;
                last_edge = k;
                res       = data_result;
                exc       = data_exception;
            end
            if (busy === 1'b1) busy_cnt++;
        end
    endtask

    task automatic do_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int           pulses;
        int           last_edge;
        int           busy_cnt;
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] exp_q;
        logic         exp_e;
        model(a, b, exp_q, exp_e);
        start_op(a, b);
        watch(LATENCY + 3, pulses, last_edge, res, exc, busy_cnt);
        check({tag, "_rdy_edge"}, last_edge, LATENCY);
        check({tag, "_rdy_count"}, pulses, 1);
        check({tag, "_busy_cycles"}, busy_cnt, LATENCY - 1);
        check({tag, "_result"}, res, exp_q);
        check({tag, "_exception"}, exc, exp_e);
    endtask

    initial begin
        int           pulses;
        int           last_edge;
        int           busy_cnt;
        logic [W-1:0] res;
        logic         exc;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #12;
        check("reset_result", data_result, '0);
        check("reset_exception", data_exception, '0);
        check("reset_rdy", data_resultRDY, '0);
        check("reset_busy", busy, '0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        do_div("pos_pos", 32'd100, 32'd7);
        do_div("neg_pos", -32'sd100, 32'd7);
        do_div("pos_neg", 32'd100, -32'sd7);
        do_div("neg_neg", -32'sd100, -32'sd7);
        do_div("div_zero", 32'd5, 32'd0);
        repeat (6) @(posedge clock);
        #1;
        check("hold_exception", data_exception, 1'b1);
        check("hold_result", data_result, '0);
        check("hold_rdy", data_resultRDY, 1'b0);
        do_div("overflow", INT_MIN, NEG_ONE);
        do_div("int_min_by_2", INT_MIN, 32'd2);
        do_div("int_min_by_int_min", INT_MIN, INT_MIN);
        do_div("small_by_large", 32'd3, 32'hFFFF_FF00);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       b = W'($urandom_range(1, 50));
                1:       b = W'(0) - W'($urandom_range(1, 50));
                2:       b = $urandom;
                default: b = ($urandom_range(0, 1) == 1) ? '0 : NEG_ONE;
            endcase
            a = ($urandom_range(0, 7) == 0) ? INT_MIN : $urandom;
            do_div($sformatf("rand%0d", i), a, b);
        end

        // Start on the fix-up edge: finishing result still reported, busy stays high.
        start_op(32'd1000, 32'd10);
        watch(LATENCY - 1, pulses, last_edge, res, exc, busy_cnt);
        check("ovl_no_early_rdy", pulses, 0);
        ctrl_DIV      = 1'b1;
        data_operandA = -32'sd63;
        data_operandB = 32'd4;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        check("ovl_first_rdy", data_resultRDY, 1'b1);
        check("ovl_first_result", data_result, 32'd100);
        check("ovl_busy_kept", busy, 1'b1);
        watch(LATENCY + 3, pulses, last_edge, res, exc, busy_cnt);
        check("ovl_second_edge", last_edge, LATENCY);
        check("ovl_second_count", pulses, 1);
        check("ovl_second_result", res, -32'sd15);

        // Restart at edge 10: only the second operation reports, at edge 43.
        start_op(32'd100, 32'd7);
        watch(9, pulses, last_edge, res, exc, busy_cnt);
        check("restart_no_rdy_before", pulses, 0);
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd81;
        data_operandB = 32'd9;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        watch(LATENCY + 6, pulses, last_edge, res, exc, busy_cnt);
        check("restart_rdy_count", pulses, 1);
        check("restart_rdy_edge", last_edge + 10, 43);
        check("restart_result", res, 32'd9);

        // Asynchronous reset mid-operation clears outputs at once.
        start_op(32'd1000, 32'd3);
        watch(19, pulses, last_edge, res, exc, busy_cnt);
        check("rst_mid_busy_before", busy, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_result", data_result, '0);
        check("rst_mid_exception", data_exception, '0);
        check("rst_mid_rdy", data_resultRDY, '0);
        check("rst_mid_busy", busy, '0);
        @(negedge clock);
        reset = 1'b0;
        watch(LATENCY + 10, pulses, last_edge, res, exc, busy_cnt);
        check("rst_mid_no_rdy", pulses, 0);
        check("rst_mid_no_busy", busy_cnt, 0);
        check("rst_mid_result_after", data_result, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
